// File: rtl/alu_pkg.sv
// alu_pkg: shared opcode constants, instruction field positions and a small
// helper for the ALU decode unit.
package alu_pkg;

  // Instruction field bit positions (instr[5:0] carries no information).
  localparam int OPC_HI   = 15;
  localparam int OPC_LO   = 12;
  localparam int ADDR1_HI = 11;
  localparam int ADDR1_LO = 9;
  localparam int ADDR2_HI = 8;
  localparam int ADDR2_LO = 6;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_NOT  = 4'd5;
  localparam logic [3:0] OP_SHL  = 4'd6;
  localparam logic [3:0] OP_SHR  = 4'd7;
  localparam logic [3:0] OP_SAR  = 4'd8;
  localparam logic [3:0] OP_ROL  = 4'd9;
  localparam logic [3:0] OP_ROR  = 4'd10;
  localparam logic [3:0] OP_INC  = 4'd11;
  localparam logic [3:0] OP_DEC  = 4'd12;
  localparam logic [3:0] OP_MOV  = 4'd13;
  localparam logic [3:0] OP_CMP  = 4'd14;
  localparam logic [3:0] OP_SHOW = 4'd15;

  // Every opcode except CMP and SHOW writes its result back to addr1.
  function automatic logic op_writes(input logic [3:0] op);
    return (op != OP_CMP) && (op != OP_SHOW);
  endfunction

endpackage

// File: rtl/alu_core.sv
// alu_core: combinational result and next-flag computation.
// Ports:
//   in1, in2 [WIDTH-1:0] : operands A and B
//   alu_op   [3:0]       : operation code
//   res      [WIDTH-1:0] : result
//   cf_nxt, zf_nxt, sf_nxt, of_nxt : flag values to load on the next edge
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [3:0]       alu_op,
  output logic [WIDTH-1:0] res,
  output logic             cf_nxt,
  output logic             zf_nxt,
  output logic             sf_nxt,
  output logic             of_nxt
);

  // INC/DEC share the adder and subtractor with a constant operand of 1.
  logic        [WIDTH-1:0] opb;
  logic        [WIDTH:0]   sum_u;
  logic        [WIDTH:0]   dif_u;
  logic signed [WIDTH:0]   sum_s;
  logic signed [WIDTH:0]   dif_s;

  assign opb = ((alu_op == OP_INC) || (alu_op == OP_DEC)) ? WIDTH'(1) : in2;

  // Unsigned extension gives carry/borrow in the top bit; sign extension
  // exposes signed overflow as a mismatch between the two top bits.
  assign sum_u = {1'b0, in1} + {1'b0, opb};
  assign dif_u = {1'b0, in1} - {1'b0, opb};
  assign sum_s = $signed({in1[WIDTH-1], in1}) + $signed({opb[WIDTH-1], opb});
  assign dif_s = $signed({in1[WIDTH-1], in1}) - $signed({opb[WIDTH-1], opb});

  always_comb begin
    res    = in1;
    cf_nxt = 1'b0;
    of_nxt = 1'b0;
    case (alu_op)
      OP_ADD, OP_INC: begin
        res    = sum_u[WIDTH-1:0];
        cf_nxt = sum_u[WIDTH];
        of_nxt = sum_s[WIDTH] ^ sum_s[WIDTH-1];
      end
      OP_SUB, OP_CMP, OP_DEC: begin
        res    = dif_u[WIDTH-1:0];
        cf_nxt = dif_u[WIDTH];
        of_nxt = dif_s[WIDTH] ^ dif_s[WIDTH-1];
      end
      OP_AND: res = in1 & in2;
      OP_OR:  res = in1 | in2;
      OP_XOR: res = in1 ^ in2;
      OP_NOT: res = ~in1;
      OP_SHL: begin
        res    = {in1[WIDTH-2:0], 1'b0};
        cf_nxt = in1[WIDTH-1];
      end
      OP_SHR: begin
        res    = {1'b0, in1[WIDTH-1:1]};
        cf_nxt = in1[0];
      end
      OP_SAR: begin
        res    = {in1[WIDTH-1], in1[WIDTH-1:1]};
        cf_nxt = in1[0];
      end
      OP_ROL: begin
        res    = {in1[WIDTH-2:0], in1[WIDTH-1]};
        cf_nxt = in1[WIDTH-1];
      end
      OP_ROR: begin
        res    = {in1[0], in1[WIDTH-1:1]};
        cf_nxt = in1[0];
      end
      OP_MOV:  res = in2;
      default: res = in1;  // SHOW passes operand A through for display
    endcase
  end

  assign zf_nxt = (res == '0);
  assign sf_nxt = res[WIDTH-1];

endmodule

// File: rtl/alu_decode_unit.sv
// alu_decode_unit: instruction decode, combinational ALU result and
// registered status flags.
// Ports:
//   clock, reset         : clock; asynchronous active-high reset (flags only)
//   instr [15:0]         : instruction word {op, addr1, addr2, unused[5:0]}
//   in1, in2 [WIDTH-1:0] : operands read from addr1 / addr2
//   alu_op, addr1, addr2 : decoded fields
//   show, write          : display strobe, register write enable
//   res [WIDTH-1:0]      : result, same cycle as instr
//   CF, ZF, SF, OF       : flags of the previous non-SHOW operation
module alu_decode_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [15:0]      instr,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic [3:0]       alu_op,
  output logic [2:0]       addr1,
  output logic [2:0]       addr2,
  output logic             show,
  output logic             write,
  output logic [WIDTH-1:0] res,
  output logic             CF,
  output logic             ZF,
  output logic             SF,
  output logic             OF
);

  logic cf_nxt;
  logic zf_nxt;
  logic sf_nxt;
  logic of_nxt;
  logic unused_instr_bits;

  assign alu_op = instr[OPC_HI:OPC_LO];
  assign addr1  = instr[ADDR1_HI:ADDR1_LO];
  assign addr2  = instr[ADDR2_HI:ADDR2_LO];
  assign show   = (alu_op == OP_SHOW);
  assign write  = op_writes(alu_op);
  assign unused_instr_bits = ^instr[ADDR2_LO-1:0];

  alu_core #(.WIDTH(WIDTH)) u_core (
    .in1    (in1),
    .in2    (in2),
    .alu_op (alu_op),
    .res    (res),
    .cf_nxt (cf_nxt),
    .zf_nxt (zf_nxt),
    .sf_nxt (sf_nxt),
    .of_nxt (of_nxt)
  );

  // ---- stage boundary: flags registered one clock after res ----
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      CF <= 1'b0;
      ZF <= 1'b0;
      SF <= 1'b0;
      OF <= 1'b0;
    end else if (!show) begin
      CF <= cf_nxt;
      ZF <= zf_nxt;
      SF <= sf_nxt;
      OF <= of_nxt;
    end
  end

endmodule

// File: tb/tb_alu_decode_unit.sv
module tb_alu_decode_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] instr = 16'h0000;
  logic [7:0]  in1   = 8'h00;
  logic [7:0]  in2   = 8'h00;
  logic [3:0]  alu_op;
  logic [2:0]  addr1;
  logic [2:0]  addr2;
  logic        show;
  logic        write;
  logic [7:0]  res;
  logic        CF, ZF, SF, OF;

  int n_vec = 0;
  int n_err = 0;
  bit check_en = 1'b0;

  // Reference flag state, kept independently of the DUT.
  bit m_cf = 0, m_zf = 0, m_sf = 0, m_of = 0;

  alu_decode_unit #(.WIDTH(8)) dut (
    .clock  (clock),
    .reset  (reset),
    .instr  (instr),
    .in1    (in1),
    .in2    (in2),
    .alu_op (alu_op),
    .addr1  (addr1),
    .addr2  (addr2),
    .show   (show),
    .write  (write),
    .res    (res),
    .CF     (CF),
    .ZF     (ZF),
    .SF     (SF),
    .OF     (OF)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int to_s(input int v);
    return (v >= 128) ? v - 256 : v;
  endfunction

  // Reference model in plain integer arithmetic.
  task automatic model(input int op, input int a, input int b,
                       output int r, output int c, output int o);
    int t, s;
    c = 0; o = 0; r = a; s = 0;
    case (op)
      0:  begin t = a + b; c = (t > 255); s = to_s(a) + to_s(b); r = t % 256; end
      1, 14: begin t = a - b; c = (a < b); s = to_s(a) - to_s(b); r = (t + 256) % 256; end
      2:  r = a & b;
      3:  r = a | b;
      4:  r = a ^ b;
      5:  r = 255 - a;
      6:  begin r = (a * 2) % 256; c = (a >= 128); end
      7:  begin r = a / 2; c = a % 2; end
      8:  begin r = a / 2 + ((a >= 128) ? 128 : 0); c = a % 2; end
      9:  begin r = (a * 2) % 256 + a / 128; c = (a >= 128); end
      10: begin r = a / 2 + (a % 2) * 128; c = a % 2; end
      11: begin t = a + 1; c = (t > 255); s = to_s(a) + 1; r = t % 256; end
      12: begin t = a - 1; c = (a < 1); s = to_s(a) - 1; r = (t + 256) % 256; end
      13: r = b;
      default: r = a;
    endcase
    if (op == 0 || op == 1 || op == 14 || op == 11 || op == 12)
      o = (s > 127) || (s < -128);
  endtask

  // Model flag register.
  always @(posedge clock or posedge reset) begin
    int r, c, o;
    if (reset) begin
      m_cf <= 0; m_zf <= 0; m_sf <= 0; m_of <= 0;
    end else if (instr[15:12] != 4'd15) begin
      model(int'(instr[15:12]), int'(in1), int'(in2), r, c, o);
      m_cf <= bit'(c); m_of <= bit'(o);
      m_zf <= (r == 0); m_sf <= (r >= 128);
    end
  end

  // Compare process: every falling edge, all outputs against the model.
  always @(negedge clock) begin
    int r, c, o, op;
    if (check_en) begin
      op = int'(instr[15:12]);
      model(op, int'(in1), int'(in2), r, c, o);
      chk("res",    int'(res),    r);
      chk("alu_op", int'(alu_op), op);
      chk("addr1",  int'(addr1),  int'(instr[11:9]));
      chk("addr2",  int'(addr2),  int'(instr[8:6]));
      chk("write",  int'(write),  (op < 14) ? 1 : 0);
      chk("show",   int'(show),   (op == 15) ? 1 : 0);
      chk("CF", int'(CF), int'(m_cf));
      chk("ZF", int'(ZF), int'(m_zf));
      chk("SF", int'(SF), int'(m_sf));
      chk("OF", int'(OF), int'(m_of));
    end
  end

  // Drive a vector just after a rising edge and let it settle.
  task automatic step(input logic [15:0] i, input logic [7:0] a, input logic [7:0] b);
    @(posedge clock);
    #1;
    instr = i; in1 = a; in2 = b;
    #1;
  endtask

  // Wait for the edge that captures the current vector's flags.
  task automatic edge_wait();
    @(posedge clock);
    #1;
  endtask

  initial begin
    #3;
    chk("rst_CF", int'(CF), 0);
    chk("rst_ZF", int'(ZF), 0);
    @(posedge clock); #1;
    reset = 1'b0;
    check_en = 1'b1;

    // ADD 0xFF + 0x01 into addr1=1 from addr2=1
    step(16'h0240, 8'hFF, 8'h01);
    chk("add_res", int'(res), 'h00);
    chk("add_write", int'(write), 1);
    chk("add_addr1", int'(addr1), 1);
    edge_wait();
    chk("add_CF", int'(CF), 1);
    chk("add_ZF", int'(ZF), 1);
    chk("add_SF", int'(SF), 0);
    chk("add_OF", int'(OF), 0);

    // Asynchronous reset with flags set: clears before any edge
    #1 reset = 1'b1;
    #1;
    chk("async_CF", int'(CF), 0);
    chk("async_ZF", int'(ZF), 0);
    @(posedge clock); #1;
    reset = 1'b0;

    // CMP 5 - 5
    step(16'hE000, 8'h05, 8'h05);
    chk("cmp_write", int'(write), 0);
    chk("cmp_res", int'(res), 'h00);
    edge_wait();
    chk("cmp_ZF", int'(ZF), 1);
    chk("cmp_CF", int'(CF), 0);

    // SAR / ROL of 0x81
    step(16'h8000, 8'h81, 8'h00);
    chk("sar_res", int'(res), 'hC0);
    edge_wait();
    chk("sar_CF", int'(CF), 1);
    step(16'h9000, 8'h81, 8'h00);
    chk("rol_res", int'(res), 'h03);
    edge_wait();
    chk("rol_CF", int'(CF), 1);

    // SUB wrap cases
    step(16'h1000, 8'h00, 8'h01);
    chk("sub0_res", int'(res), 'hFF);
    edge_wait();
    chk("sub0_CF", int'(CF), 1);
    chk("sub0_SF", int'(SF), 1);
    step(16'h1000, 8'h80, 8'h01);
    chk("sub80_res", int'(res), 'h7F);
    edge_wait();
    chk("sub80_OF", int'(OF), 1);

    // ADD 0x7F + 0x01, then SHOW must hold its flags
    step(16'h0000, 8'h7F, 8'h01);
    chk("add7f_res", int'(res), 'h80);
    step(16'hF000, 8'h3C, 8'h00);
    chk("show_show", int'(show), 1);
    chk("show_write", int'(write), 0);
    chk("show_res", int'(res), 'h3C);
    chk("add7f_OF", int'(OF), 1);
    chk("add7f_SF", int'(SF), 1);
    chk("add7f_CF", int'(CF), 0);
    edge_wait();
    chk("hold_OF", int'(OF), 1);
    chk("hold_SF", int'(SF), 1);

    // Sweep all opcodes with random operands and field bits
    for (int op = 0; op < 16; op++) begin
      for (int k = 0; k < 4; k++) begin
        step({4'(op), 12'($urandom_range(0, 4095))},
             8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      end
    end
    step(16'h0000, 8'h00, 8'h00);
    edge_wait();
    check_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
